// File: rtl/f2i_pkg.sv
`default_nettype none
// ============================================================================
//  Module : f2i_pkg
//  Brief  : Shared constants and FSM encoding for the FP16 -> integer converter.
//  Rev    : 1.0  initial release
// ============================================================================
package f2i_pkg;

    localparam int FP_W              = 16;
    localparam int EXP_W             = 5;
    localparam int MAN_W             = 10;
    localparam int BIAS              = 15;
    localparam int EXP_SAT           = 30;
    localparam int MEM_DEPTH_DEFAULT = 256;
    localparam int IN_ADDR_DEFAULT   = 64;
    localparam int OUT_ADDR_DEFAULT  = 66;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_HI = 3'd1,
        ST_RD_LO = 3'd2,
        ST_CONV  = 3'd3,
        ST_WR_HI = 3'd4,
        ST_WR_LO = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/data_mem.sv
`default_nettype none
// ============================================================================
//  Module : data_mem
//  Brief  : Byte-wide data memory, combinational read, synchronous write.
//  Rev    : 1.0  initial release
// ============================================================================
module data_mem
    import f2i_pkg::*;
#(
    parameter int MEM_DEPTH = MEM_DEPTH_DEFAULT,
    parameter int ADDR_W    = $clog2(MEM_DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        din,
    output logic [7:0]        dout
);

    // Contents are intentionally not reset; the operand is preloaded externally.
    logic [7:0] my_memory [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            my_memory[addr] <= din;
        end
    end

    assign dout = my_memory[addr];

endmodule
`default_nettype wire

// File: rtl/top_float_to_int.sv
`default_nettype none
// ============================================================================
//  Module : top_float_to_int
//  Brief  : Reads an FP16 operand from memory, truncates/saturates it to a
//           16-bit sign-magnitude integer and writes the result back.
//  Rev    : 1.0  initial release
// ============================================================================
module top_float_to_int
    import f2i_pkg::*;
#(
    parameter int MEM_DEPTH = MEM_DEPTH_DEFAULT,
    parameter int IN_ADDR   = IN_ADDR_DEFAULT,
    parameter int OUT_ADDR  = OUT_ADDR_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    output logic done
);

    localparam int ADDR_W = $clog2(MEM_DEPTH);

    localparam logic [ADDR_W-1:0] c_in_hi   = ADDR_W'(IN_ADDR);
    localparam logic [ADDR_W-1:0] c_in_lo   = ADDR_W'(IN_ADDR + 1);
    localparam logic [ADDR_W-1:0] c_out_hi  = ADDR_W'(OUT_ADDR);
    localparam logic [ADDR_W-1:0] c_out_lo  = ADDR_W'(OUT_ADDR + 1);
    localparam logic [EXP_W-1:0]  c_bias    = EXP_W'(BIAS);
    localparam logic [EXP_W-1:0]  c_exp_sat = EXP_W'(EXP_SAT);

    state_t r_state;
    state_t w_next;

    logic [7:0]        r_op_hi;
    logic [7:0]        r_op_lo;
    logic [FP_W-1:0]   r_result;

    logic              w_wr_en;
    logic [ADDR_W-1:0] w_addr;
    logic [7:0]        w_din;
    logic [7:0]        w_dout;

    logic              w_sign;
    logic [EXP_W-1:0]  w_exp;
    logic [MAN_W-1:0]  w_man;
    logic [3:0]        w_shift;
    logic [24:0]       w_shifted;
    logic [14:0]       w_mag;

    data_mem #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_W    (ADDR_W)
    ) data_mem1 (
        .clk   (clk),
        .wr_en (w_wr_en),
        .addr  (w_addr),
        .din   (w_din),
        .dout  (w_dout)
    );

    // ---------------------------------------------------------------- datapath
    assign w_sign    = r_op_hi[7];
    assign w_exp     = r_op_hi[6:2];
    assign w_man     = {r_op_hi[1:0], r_op_lo};
    assign w_shift   = 4'(w_exp - c_bias);
    // 25 bits holds the hidden-one mantissa shifted by the largest unsaturated exponent (14).
    assign w_shifted = {14'd0, 1'b1, w_man} << w_shift;

    always_comb begin
        w_mag = 15'd0;
        if (w_exp >= c_exp_sat) begin
            w_mag = 15'h7FFF;
        end else if (w_exp >= c_bias) begin
            w_mag = w_shifted[24:10];
        end
    end

    // --------------------------------------------------------------------- FSM
    always_comb begin
        w_next  = r_state;
        w_wr_en = 1'b0;
        w_addr  = c_in_hi;
        w_din   = 8'd0;
        case (r_state)
            ST_IDLE:  w_next = ST_RD_HI;
            ST_RD_HI: begin
                w_addr = c_in_hi;
                w_next = ST_RD_LO;
            end
            ST_RD_LO: begin
                w_addr = c_in_lo;
                w_next = ST_CONV;
            end
            ST_CONV:  w_next = ST_WR_HI;
            ST_WR_HI: begin
                w_wr_en = 1'b1;
                w_addr  = c_out_hi;
                w_din   = r_result[15:8];
                w_next  = ST_WR_LO;
            end
            ST_WR_LO: begin
                w_wr_en = 1'b1;
                w_addr  = c_out_lo;
                w_din   = r_result[7:0];
                w_next  = ST_DONE;
            end
            ST_DONE:  w_next = ST_DONE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_op_hi  <= 8'd0;
            r_op_lo  <= 8'd0;
            r_result <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_RD_HI) r_op_hi  <= w_dout;
            if (r_state == ST_RD_LO) r_op_lo  <= w_dout;
            if (r_state == ST_CONV)  r_result <= {w_sign, w_mag};
        end
    end

    assign done = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_top_float_to_int.sv
`default_nettype none
// ============================================================================
//  Module : tb_top_float_to_int
//  Brief  : Scoreboard bench for top_float_to_int (directed table + random).
//  Rev    : 1.0  initial release
// ============================================================================
module tb_top_float_to_int;

    localparam int IN_A  = 64;
    localparam int OUT_A = 66;

    logic clk;
    logic reset;
    logic done;

    int          n_vectors;
    int          n_miscompares;
    logic [15:0] sb_q[$];

    top_float_to_int #(
        .MEM_DEPTH (256),
        .IN_ADDR   (IN_A),
        .OUT_ADDR  (OUT_A)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vectors++;
        if (obs !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Floor of |value| computed by repeated doubling, independent of bit slicing.
    function automatic logic [15:0] golden(input logic [15:0] f);
        int unsigned  e_raw;
        longint       val;
        logic [14:0]  mag;
        e_raw = int'(f[14:10]);
        if (e_raw >= 30) begin
            mag = 15'h7FFF;
        end else if (e_raw < 15) begin
            mag = 15'd0;
        end else begin
            val = 1024 + longint'(f[9:0]);
            for (int k = 15; k < int'(e_raw); k++) val = val * 2;
            mag = 15'(val / 1024);
        end
        return {f[15], mag};
    endfunction

    task automatic load_operand(input logic [15:0] op);
        dut.data_mem1.my_memory[IN_A]      = op[15:8];
        dut.data_mem1.my_memory[IN_A + 1]  = op[7:0];
        dut.data_mem1.my_memory[OUT_A]     = 8'hA5;
        dut.data_mem1.my_memory[OUT_A + 1] = 8'hA5;
    endtask

    // Two-clock reset pulse, then run one conversion and compare against the scoreboard.
    task automatic run_vector(input string tag, input logic [15:0] op, input logic [15:0] exp);
        int          cyc;
        logic [15:0] want;
        reset = 1'b1;
        @(negedge clk);
        chk({tag, "_done_drop"}, {15'd0, done}, 16'd0);
        load_operand(op);
        sb_q.push_back(exp);
        @(negedge clk);
        reset = 1'b0;
        cyc = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin
                cyc = i;
                break;
            end
        end
        if (cyc == 0) cyc = 21;
        chk({tag, "_latency"}, 16'(cyc), 16'd6);
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 16'd1, 16'd0);
        end else begin
            want = sb_q.pop_front();
            chk({tag, "_result"},
                {dut.data_mem1.my_memory[OUT_A], dut.data_mem1.my_memory[OUT_A + 1]}, want);
        end
    endtask

    typedef struct {
        logic [15:0] op;
        logic [15:0] res;
    } vec_t;

    vec_t dir_tab[12];

    initial begin
        logic [15:0] rop;
        n_vectors     = 0;
        n_miscompares = 0;

        dir_tab[0]  = '{16'hC204, 16'h8003};
        dir_tab[1]  = '{16'hCA10, 16'h800C};
        dir_tab[2]  = '{16'hD20F, 16'h8030};
        dir_tab[3]  = '{16'h7800, 16'h7FFF};
        dir_tab[4]  = '{16'h7C00, 16'h7FFF};
        dir_tab[5]  = '{16'hFC00, 16'hFFFF};
        dir_tab[6]  = '{16'h77FF, 16'h7FF0};
        dir_tab[7]  = '{16'h3BFF, 16'h0000};
        dir_tab[8]  = '{16'h3C00, 16'h0001};
        dir_tab[9]  = '{16'hBC00, 16'h8001};
        dir_tab[10] = '{16'h0001, 16'h0000};
        dir_tab[11] = '{16'h8000, 16'h8000};

        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_done", {15'd0, done}, 16'd0);

        foreach (dir_tab[i]) begin
            run_vector($sformatf("dir%0d", i), dir_tab[i].op, dir_tab[i].res);
        end

        // Abort in CONV: edges 1..3 take the FSM IDLE->RD_HI->RD_LO->CONV.
        reset = 1'b1;
        @(negedge clk);
        load_operand(16'hC204);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_done", {15'd0, done}, 16'd0);
        repeat (3) @(negedge clk);
        chk("abort_done_hold", {15'd0, done}, 16'd0);
        chk("abort_no_write",
            {dut.data_mem1.my_memory[OUT_A], dut.data_mem1.my_memory[OUT_A + 1]}, 16'hA5A5);
        run_vector("rerun", 16'hCA10, 16'h800C);

        for (int i = 0; i < 20; i++) begin
            rop = 16'($urandom_range(0, 65535));
            run_vector($sformatf("rnd%0d", i), rop, golden(rop));
        end

        reset = 1'b1;
        @(negedge clk);
        chk("final_done_drop", {15'd0, done}, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
`default_nettype wire
